// File: rtl/ofs_plat_shim_ccip_wr_rsp_unpack.sv
// CCI-P c1Rx write-response unpacker: buffers incoming response flits and expands
// each packed multi-line write ACK into one unpacked ACK per line.
module ofs_plat_shim_ccip_wr_rsp_unpack #(
    parameter int FIFO_DEPTH     = 16,
    parameter int ALM_FULL_SLACK = 4,
    parameter int MDATA_WIDTH    = 16,
    parameter int CL_NUM_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_is_wr,
    input  logic                    in_packed,
    input  logic [CL_NUM_WIDTH-1:0] in_cl_num,
    input  logic [3:0]              in_type,
    input  logic [MDATA_WIDTH-1:0]  in_mdata,
    output logic                    out_valid,
    output logic [3:0]              out_type,
    output logic                    out_packed,
    output logic [CL_NUM_WIDTH-1:0] out_cl_num,
    output logic [MDATA_WIDTH-1:0]  out_mdata,
    output logic                    alm_full,
    output logic                    overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALM_LVL  = CW'(FIFO_DEPTH - ALM_FULL_SLACK);

    typedef struct packed {
        logic                    is_wr;
        logic                    fmt;
        logic [CL_NUM_WIDTH-1:0] cl_num;
        logic [3:0]              rtype;
        logic [MDATA_WIDTH-1:0]  mdata;
    } entry_t;

    typedef enum logic {IDLE, EMIT} state_t;

    entry_t                  mem [FIFO_DEPTH];
    entry_t                  head, cur, cur_n;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, count_n;
    state_t                  state, state_n;
    logic [CL_NUM_WIDTH-1:0] beat, beat_n;
    logic                    ready, enq, deq, expand;
    logic                    out_valid_n, out_packed_n;
    logic [3:0]              out_type_n;
    logic [CL_NUM_WIDTH-1:0] out_cl_num_n;
    logic [MDATA_WIDTH-1:0]  out_mdata_n;

    assign head = mem[rd_ptr];
    // The expander is free once its last beat has gone out, so the next head can be
    // popped and its beat 0 emitted on the very next edge without a bubble.
    assign ready = (state == IDLE) || (beat == cur.cl_num);
    assign deq   = ready && (count != '0);
    assign enq   = in_valid && ((count != FULL_LVL) || deq);

    always_comb begin
        count_n = count;
        if (enq && !deq)
            count_n = count + CW'(1);
        else if (!enq && deq)
            count_n = count - CW'(1);
    end

    always_comb begin
        state_n      = state;
        beat_n       = beat;
        cur_n        = cur;
        expand       = 1'b0;
        out_valid_n  = 1'b0;
        out_type_n   = out_type;
        out_packed_n = out_packed;
        out_cl_num_n = out_cl_num;
        out_mdata_n  = out_mdata;
        if (ready) begin
            state_n = IDLE;
            if (deq) begin
                expand       = head.is_wr && head.fmt;
                cur_n        = head;
                beat_n       = '0;
                out_valid_n  = 1'b1;
                out_type_n   = head.rtype;
                out_mdata_n  = head.mdata;
                out_packed_n = expand ? 1'b0 : head.fmt;
                out_cl_num_n = expand ? '0 : head.cl_num;
                if (expand && (head.cl_num != '0))
                    state_n = EMIT;
            end
        end else begin
            beat_n       = beat + CL_NUM_WIDTH'(1);
            out_valid_n  = 1'b1;
            out_type_n   = cur.rtype;
            out_mdata_n  = cur.mdata;
            out_packed_n = 1'b0;
            out_cl_num_n = beat + CL_NUM_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= '{is_wr: in_is_wr, fmt: in_packed, cl_num: in_cl_num,
                             rtype: in_type, mdata: in_mdata};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= '0;
            cur        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_type   <= '0;
            out_packed <= 1'b0;
            out_cl_num <= '0;
            out_mdata  <= '0;
            alm_full   <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            cur        <= cur_n;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count      <= count_n;
            out_valid  <= out_valid_n;
            out_type   <= out_type_n;
            out_packed <= out_packed_n;
            out_cl_num <= out_cl_num_n;
            out_mdata  <= out_mdata_n;
            alm_full   <= (count_n >= ALM_LVL);
            if (in_valid && !enq) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofs_plat_shim_ccip_wr_rsp_unpack.sv
// Directed bench for the c1Rx write-response unpacker.
`timescale 1ns/1ps
module tb_ofs_plat_shim_ccip_wr_rsp_unpack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_is_wr = 1'b0, in_packed = 1'b0;
    logic [1:0]  in_cl_num = '0;
    logic [3:0]  in_type = '0;
    logic [15:0] in_mdata = '0;
    logic        out_valid, out_packed, alm_full, overflow;
    logic [3:0]  out_type;
    logic [1:0]  out_cl_num;
    logic [15:0] out_mdata;

    int n_vec = 0;
    int n_err = 0;
    logic        mon_en = 1'b0;
    int          mon_cnt = 0;
    logic [15:0] mon_last = '0;

    ofs_plat_shim_ccip_wr_rsp_unpack #(
        .FIFO_DEPTH(16), .ALM_FULL_SLACK(4), .MDATA_WIDTH(16), .CL_NUM_WIDTH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_is_wr(in_is_wr), .in_packed(in_packed),
        .in_cl_num(in_cl_num), .in_type(in_type), .in_mdata(in_mdata),
        .out_valid(out_valid), .out_type(out_type), .out_packed(out_packed),
        .out_cl_num(out_cl_num), .out_mdata(out_mdata),
        .alm_full(alm_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            mon_cnt  = mon_cnt + 1;
            mon_last = out_mdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic pk, input logic [1:0] cl,
                        input logic [3:0] ty, input logic [15:0] md);
        in_valid = 1'b1; in_is_wr = wr; in_packed = pk;
        in_cl_num = cl; in_type = ty; in_mdata = md;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_flit(input string tag, input logic pk, input logic [1:0] cl,
                            input logic [3:0] ty, input logic [15:0] md);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".packed"}, 32'(out_packed), 32'(pk));
        check({tag, ".cl_num"}, 32'(out_cl_num), 32'(cl));
        check({tag, ".type"}, 32'(out_type), 32'(ty));
        check({tag, ".mdata"}, 32'(out_mdata), 32'(md));
    endtask

    initial begin
        // reset values
        tick(); tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        check("rst.alm_full", 32'(alm_full), 32'd1);
        check("rst.cl_num", 32'(out_cl_num), 32'd0);
        check("rst.mdata", 32'(out_mdata), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rel.alm_full", 32'(alm_full), 32'd0);

        // packed write ACK, cl_num=3: four beats at T+2..T+5
        send(1'b1, 1'b1, 2'd3, 4'h1, 16'h0012);
        check("pk3.lat", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_flit($sformatf("pk3.b%0d", i), 1'b0, 2'(i), 4'h1, 16'h0012);
        end
        tick();
        check("pk3.end", 32'(out_valid), 32'd0);

        // unpacked write and non-write flit pass through unchanged
        send(1'b1, 1'b0, 2'd2, 4'h1, 16'h0007);
        send(1'b0, 1'b1, 2'd3, 4'h4, 16'h0055);
        chk_flit("unpk", 1'b0, 2'd2, 4'h1, 16'h0007);
        tick();
        chk_flit("nonwr", 1'b1, 2'd3, 4'h4, 16'h0055);
        tick();
        check("pass.end", 32'(out_valid), 32'd0);

        // back-to-back packed ACKs: A0 A1 B0 B1 B2 with no bubble
        send(1'b1, 1'b1, 2'd1, 4'h1, 16'h000A);
        send(1'b1, 1'b1, 2'd2, 4'h1, 16'h000B);
        chk_flit("b2b.A0", 1'b0, 2'd0, 4'h1, 16'h000A);
        tick(); chk_flit("b2b.A1", 1'b0, 2'd1, 4'h1, 16'h000A);
        tick(); chk_flit("b2b.B0", 1'b0, 2'd0, 4'h1, 16'h000B);
        tick(); chk_flit("b2b.B1", 1'b0, 2'd1, 4'h1, 16'h000B);
        tick(); chk_flit("b2b.B2", 1'b0, 2'd2, 4'h1, 16'h000B);
        tick();
        check("b2b.end", 32'(out_valid), 32'd0);
        tick();

        // continuous packed cl_num=3 stream: count hits 12 after input 16,
        // full after input 21, input 22 dequeues-while-full, input 23 is dropped
        mon_cnt = 0;
        mon_en  = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            send(1'b1, 1'b1, 2'd3, 4'h1, 16'(k - 1));
            if (k == 15) check("fill.alm15", 32'(alm_full), 32'd0);
            if (k == 16) check("fill.alm16", 32'(alm_full), 32'd1);
            if (k == 21) check("fill.ovf21", 32'(overflow), 32'd0);
            if (k == 22) check("fill.ovf22", 32'(overflow), 32'd0);
            if (k == 23) check("fill.ovf23", 32'(overflow), 32'd1);
        end
        for (int i = 0; i < 300 && mon_cnt < 88; i++) tick();
        tick(); tick();
        mon_en = 1'b0;
        check("fill.flits", 32'(mon_cnt), 32'd88);
        check("fill.last", 32'(mon_last), 32'd21);
        check("fill.idle", 32'(out_valid), 32'd0);
        check("fill.alm_dr", 32'(alm_full), 32'd0);
        check("fill.ovf_sticky", 32'(overflow), 32'd1);

        // reset during beat 1 of a 4-line expansion with another packet pending
        send(1'b1, 1'b1, 2'd3, 4'h1, 16'h0033);
        send(1'b1, 1'b1, 2'd3, 4'h1, 16'h0034);
        chk_flit("mid.b0", 1'b0, 2'd0, 4'h1, 16'h0033);
        tick();
        chk_flit("mid.b1", 1'b0, 2'd1, 4'h1, 16'h0033);
        reset_n = 1'b0;
        tick();
        check("mid.valid", 32'(out_valid), 32'd0);
        check("mid.alm", 32'(alm_full), 32'd1);
        check("mid.ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mid.quiet%0d", i), 32'(out_valid), 32'd0);
        end
        send(1'b1, 1'b0, 2'd1, 4'h1, 16'h0044);
        check("post.lat", 32'(out_valid), 32'd0);
        tick();
        chk_flit("post", 1'b0, 2'd1, 4'h1, 16'h0044);
        tick();
        check("post.end", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
